// File: rtl/opcode_pkg.sv
// Opcode encoding and instruction field layout shared by the immediate generator.
// Field positions assume a 32-bit instruction with the opcode in bits [31:29].
package opcode_pkg;

  typedef enum logic [2:0] {
    R_TYPE   = 3'b000,
    I_TYPE   = 3'b001,
    U_TYPE   = 3'b010,
    S_TYPE   = 3'b011,
    B_TYPE   = 3'b100,
    J_TYPE   = 3'b101,
    SYS_TYPE = 3'b110,
    P_TYPE   = 3'b111
  } opc_t;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 29;
  localparam int I_FLD_HI = 27;
  localparam int I_FLD_LO = 15;
  localparam int U_LO_HI  = 9;
  localparam int U_LO_LO  = 5;
  localparam int PFX_HI   = 27;
  localparam int PFX_LO   = 14;

  localparam int PFX_W    = 14;
  localparam int I_FLD_W  = 13;
  localparam int U_LO_W   = 5;
  localparam int U_IMM_W  = 18;
  localparam int LONG_I_W = PFX_W + I_FLD_W;
  localparam int LONG_U_W = PFX_W + U_IMM_W;

  function automatic logic is_imm_opc(input opc_t opc);
    return (opc == I_TYPE) || (opc == U_TYPE);
  endfunction

endpackage

// File: rtl/imm_fmt_comb.sv
// Combinational immediate extractor: builds the I/U immediate, optionally
// widened by a pending prefix, from one instruction.
module imm_fmt_comb
  import opcode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OUT_W   = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               pfx_pend,
  input  logic [PFX_W-1:0]   pfx_bits,
  output logic [OUT_W-1:0]   imm,
  output logic               imm_vld,
  output logic               is_long
);

  opc_t               opc;
  logic [I_FLD_W-1:0] i_fld;
  logic [U_LO_W-1:0]  u_lo;
  logic               unused_bits;

  assign opc   = opc_t'(instr[OPC_HI:OPC_LO]);
  assign i_fld = instr[I_FLD_HI:I_FLD_LO];
  assign u_lo  = instr[U_LO_HI:U_LO_LO];

  // Bits that no format reads; folded here so they are visibly accounted for.
  assign unused_bits = ^{instr[28], instr[14:10], instr[4:0]};

  // Extension is done by filling the whole word first and then overwriting
  // the low field, which keeps OUT_W free to range up to 64.
  always_comb begin
    imm     = '0;
    imm_vld = 1'b0;
    is_long = 1'b0;
    case (opc)
      I_TYPE: begin
        imm_vld = 1'b1;
        if (pfx_pend) begin
          is_long             = 1'b1;
          imm                 = {OUT_W{pfx_bits[PFX_W-1]}};
          imm[LONG_I_W-1:0]   = {pfx_bits, i_fld};
        end else begin
          imm                 = {OUT_W{i_fld[I_FLD_W-1]}};
          imm[I_FLD_W-1:0]    = i_fld;
        end
      end
      U_TYPE: begin
        imm_vld = 1'b1;
        if (pfx_pend) begin
          is_long             = 1'b1;
          imm[LONG_U_W-1:0]   = {pfx_bits, i_fld, u_lo};
        end else begin
          imm[U_IMM_W-1:0]    = {i_fld, u_lo};
        end
      end
      default: begin
        imm     = '0;
        imm_vld = 1'b0;
        is_long = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: prefix tracking on the input side, then a
// two-entry skid buffer (main + skid) toward decode.
module imm_gen_pipe
  import opcode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OUT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OUT_W-1:0]   out_imm,
  output logic               out_imm_vld,
  output logic               out_long,
  output logic               out_pfx_err
);

  generate
    if (OUT_W < 32 || OUT_W > 64) begin : g_out_w_check
      $error("imm_gen_pipe: OUT_W must lie in 32..64");
    end
  endgenerate

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [OUT_W-1:0]   imm;
    logic               imm_vld;
    logic               is_long;
    logic               pfx_err;
  } entry_t;

  entry_t           main_q;
  entry_t           skid_q;
  entry_t           new_entry;
  logic             main_valid;
  logic             skid_valid;

  logic             pfx_pend;
  logic             pfx_err_q;
  logic [PFX_W-1:0] pfx_bits;

  opc_t             in_opc;
  logic             in_is_p;
  logic             accept;
  logic             push;
  logic             pop;

  logic [OUT_W-1:0] fmt_imm;
  logic             fmt_vld;
  logic             fmt_long;

  assign in_opc  = opc_t'(in_instr[OPC_HI:OPC_LO]);
  assign in_is_p = (in_opc == P_TYPE);

  // in_ready comes straight from a flop: the block is full only when the skid holds data.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !in_is_p;
  assign pop      = main_valid && out_ready;

  imm_fmt_comb #(
    .INSTR_W (INSTR_W),
    .OUT_W   (OUT_W)
  ) u_fmt (
    .instr    (in_instr),
    .pfx_pend (pfx_pend),
    .pfx_bits (pfx_bits),
    .imm      (fmt_imm),
    .imm_vld  (fmt_vld),
    .is_long  (fmt_long)
  );

  // A prefix pending in front of a non-immediate instruction is lost and
  // reported on that instruction together with any earlier overwrite.
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = in_instr;
    new_entry.imm     = fmt_imm;
    new_entry.imm_vld = fmt_vld;
    new_entry.is_long = fmt_long;
    new_entry.pfx_err = pfx_err_q || (pfx_pend && !is_imm_opc(in_opc));
  end

  // Prefix state: a P instruction arms (or re-arms) it; any other accepted
  // instruction consumes it along with the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pfx_pend  <= 1'b0;
      pfx_err_q <= 1'b0;
      pfx_bits  <= '0;
    end else if (flush) begin
      pfx_pend  <= 1'b0;
      pfx_err_q <= 1'b0;
    end else if (accept) begin
      if (in_is_p) begin
        pfx_pend <= 1'b1;
        pfx_bits <= in_instr[PFX_HI:PFX_LO];
        if (pfx_pend) begin
          pfx_err_q <= 1'b1;
        end
      end else begin
        pfx_pend  <= 1'b0;
        pfx_err_q <= 1'b0;
      end
    end
  end

  // Skid buffer: the skid entry only fills while main is stalled, and drains
  // into main on the next pop, so order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (push) begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (push) begin
        main_q <= new_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (push) begin
      skid_q     <= new_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_instr   = main_q.instr;
  assign out_imm     = main_q.imm;
  assign out_imm_vld = main_q.imm_vld;
  assign out_long    = main_q.is_long;
  assign out_pfx_err = main_q.pfx_err;

endmodule
